bist_sequencer: RTL and testbench

Scan-BIST sequencer that drives the LFSR/MUT/MISR test datapath for the arbiter under test. Replaces the simple start/toggle controller with a parameterised pattern sequencer: it initialises the test modules, then alternates scan-shift and single-cycle functional capture for a programmed number of patterns. It then unloads the chain and compares the MISR signature against a golden value. Sits in the top level between the external bist_start/pass_fail pins and the lfsr/lfsrmux/misr instances.

---
 rtl/bist_sequencer_if.sv | 30 +++
 rtl/bist_sequencer.sv | 153 +++++++++++++++
 tb/tb_bist_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bist_sequencer_if.sv
// Control/status bundle between the BIST sequencer and the top-level pins and test datapath.
// The master modport is the sequencer's side of the bundle.
interface bist_sequencer_if #(
    parameter int MISR_BITS  = 8,
    parameter int N_PATTERNS = 32
);
    localparam int PIDX_W = $clog2(N_PATTERNS + 1);

    logic                 start;
    logic                 abort;
    logic [MISR_BITS-1:0] signature;
    logic                 init;
    logic                 running;
    logic                 scan_en;
    logic                 capture;
    logic                 busy;
    logic [PIDX_W-1:0]    pattern_idx;
    logic                 bist_end;
    logic                 pass_fail;

    modport master (
        input  start, abort, signature,
        output init, running, scan_en, capture, busy, pattern_idx, bist_end, pass_fail
    );

    modport slave (
        output start, abort, signature,
        input  init, running, scan_en, capture, busy, pattern_idx, bist_end, pass_fail
    );
endinterface

// File: rtl/bist_sequencer.sv
// Scan-BIST pattern sequencer: init, then SHIFT/CAPTURE per pattern, final UNLOAD,
// and a registered comparison of the MISR signature against the golden value.
module bist_sequencer #(
    parameter int                   SCAN_LEN        = 8,
    parameter int                   N_PATTERNS      = 32,
    parameter int                   INIT_CYCLES     = 2,
    parameter int                   MISR_BITS       = 8,
    parameter logic [MISR_BITS-1:0] SIGNATURE_VALID = 8'hF9
) (
    input  logic             clock,
    input  logic             reset,
    bist_sequencer_if.master bus
);
    localparam int CNT_MAX = (SCAN_LEN > INIT_CYCLES) ? SCAN_LEN : INIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PIDX_W  = $clog2(N_PATTERNS + 1);

    localparam logic [CNT_W-1:0]  INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SHIFT_LAST = CNT_W'(SCAN_LEN - 1);
    localparam logic [PIDX_W-1:0] PIDX_LAST  = PIDX_W'(N_PATTERNS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        UNLOAD  = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PIDX_W-1:0] pidx_q, pidx_d;
    logic              start_q, armed_q;
    logic              init_q, running_q, scan_en_q, capture_q, busy_q, bist_end_q, pass_fail_q;
    logic              start_edge_s, active_s, active_d_s;
    logic [PIDX_W-1:0] pidx_inc_s;

    // armed_q blocks a launch until start has been seen low after reset,
    // so a start already high at reset release does not count as an edge.
    assign start_edge_s = bus.start & ~start_q & armed_q;
    assign active_s     = (state_q == INIT) || (state_q == SHIFT) ||
                          (state_q == CAPTURE) || (state_q == UNLOAD);
    assign active_d_s   = (state_d == INIT) || (state_d == SHIFT) ||
                          (state_d == CAPTURE) || (state_d == UNLOAD);
    assign pidx_inc_s   = pidx_q + PIDX_W'(1'b1);

    // Next-state, phase counter and pattern index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1'b1);
        pidx_d  = pidx_q;
        case (state_q)
            IDLE, DONE: begin
                cnt_d = {CNT_W{1'b0}};
                if (start_edge_s) begin
                    state_d = INIT;
                    pidx_d  = {PIDX_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = INIT;
                end
            end
            SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    state_d = CAPTURE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = SHIFT;
                end
            end
            CAPTURE: begin
                cnt_d   = {CNT_W{1'b0}};
                pidx_d  = pidx_inc_s;
                state_d = (pidx_inc_s == PIDX_LAST) ? UNLOAD : SHIFT;
            end
            UNLOAD: begin
                if (cnt_q == SHIFT_LAST) begin
                    state_d = DONE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = UNLOAD;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
                pidx_d  = {PIDX_W{1'b0}};
            end
        endcase
        if (bus.abort && active_s) begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
            pidx_d  = {PIDX_W{1'b0}};
        end else begin
            state_d = state_d;
        end
    end

    // State registers and outputs decoded from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            pidx_q      <= {PIDX_W{1'b0}};
            start_q     <= 1'b0;
            armed_q     <= 1'b0;
            init_q      <= 1'b0;
            running_q   <= 1'b0;
            scan_en_q   <= 1'b0;
            capture_q   <= 1'b0;
            busy_q      <= 1'b0;
            bist_end_q  <= 1'b0;
            pass_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pidx_q     <= pidx_d;
            start_q    <= bus.start;
            armed_q    <= armed_q | ~bus.start;
            init_q     <= (state_d == INIT);
            running_q  <= active_d_s;
            scan_en_q  <= (state_d == SHIFT) || (state_d == UNLOAD);
            capture_q  <= (state_d == CAPTURE);
            busy_q     <= active_d_s;
            bist_end_q <= (state_d == DONE);
            // Signature is judged once on entry to DONE and then frozen.
            if ((state_q == UNLOAD) && (state_d == DONE)) begin
                pass_fail_q <= (bus.signature == SIGNATURE_VALID);
            end else if (state_d == DONE) begin
                pass_fail_q <= pass_fail_q;
            end else begin
                pass_fail_q <= 1'b0;
            end
        end
    end

    assign bus.init        = init_q;
    assign bus.running     = running_q;
    assign bus.scan_en     = scan_en_q;
    assign bus.capture     = capture_q;
    assign bus.busy        = busy_q;
    assign bus.pattern_idx = pidx_q;
    assign bus.bist_end    = bist_end_q;
    assign bus.pass_fail   = pass_fail_q;
endmodule

// File: tb/tb_bist_sequencer.sv
// Scoreboard bench: each launched run pushes its expected completion; monitors pop on bist_end rising.
module tb_bist_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    bist_sequencer_if #(.MISR_BITS(8), .N_PATTERNS(3))  ifa ();
    bist_sequencer_if #(.MISR_BITS(8), .N_PATTERNS(32)) ifb ();

    bist_sequencer #(.SCAN_LEN(4), .N_PATTERNS(3), .INIT_CYCLES(2), .MISR_BITS(8),
                     .SIGNATURE_VALID(8'hF9))
        dut_a (.clock(clock), .reset(reset), .bus(ifa));

    bist_sequencer dut_b (.clock(clock), .reset(reset), .bus(ifb));

    typedef struct {
        int end_cyc;
        int pf;
        int pidx;
        int caps;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Small config: bist_end rises 22 cycles after the cycle start is driven.
    task automatic push_a(input int k, input int pf);
        exp_t e;
        e.end_cyc = k + 22;
        e.pf      = pf;
        e.pidx    = 3;
        e.caps    = 3;
        qa.push_back(e);
    endtask

    task automatic pulse_a(output int k);
        k         = cyc;
        ifa.start = 1'b1;
        tick(1);
        ifa.start = 1'b0;
    endtask

    task automatic wait_a(input int bound);
        int n = 0;
        while (qa.size() != 0 && n < bound) begin
            tick(1);
            n++;
        end
        if (qa.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL a_timeout actual=pending required=bist_end within %0d cycles", bound);
            qa.delete();
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_init"},      ifa.init,        0);
        chk({tag, "_running"},   ifa.running,     0);
        chk({tag, "_scan_en"},   ifa.scan_en,     0);
        chk({tag, "_capture"},   ifa.capture,     0);
        chk({tag, "_busy"},      ifa.busy,        0);
        chk({tag, "_bist_end"},  ifa.bist_end,    0);
        chk({tag, "_pass_fail"}, ifa.pass_fail,   0);
        chk({tag, "_pidx"},      ifa.pattern_idx, 0);
    endtask

    initial begin : mon_a
        int   caps = 0;
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (ifa.init) caps = 0;
            else if (ifa.capture) caps++;
            if (ifa.bist_end && !prev) begin
                if (qa.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_unexpected_end actual=bist_end_rise required=none (cyc %0d)", cyc);
                end else begin
                    e = qa.pop_front();
                    chk("a_end_cycle", cyc, e.end_cyc);
                    chk("a_pass_fail", ifa.pass_fail, e.pf);
                    chk("a_pattern_idx", ifa.pattern_idx, e.pidx);
                    chk("a_captures", caps, e.caps);
                    chk("a_busy_done", ifa.busy, 0);
                    chk("a_running_done", ifa.running, 0);
                end
            end
            prev = ifa.bist_end;
        end
    end

    initial begin : mon_b
        int   caps = 0;
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (ifb.init) caps = 0;
            else if (ifb.capture) caps++;
            if (ifb.bist_end && !prev) begin
                if (qb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected_end actual=bist_end_rise required=none (cyc %0d)", cyc);
                end else begin
                    e = qb.pop_front();
                    chk("b_end_cycle", cyc, e.end_cyc);
                    chk("b_pass_fail", ifb.pass_fail, e.pf);
                    chk("b_pattern_idx", ifb.pattern_idx, e.pidx);
                    chk("b_captures", caps, e.caps);
                end
            end
            prev = ifb.bist_end;
        end
    end

    initial begin : stim
        int   k;
        int   n;
        exp_t eb;
        ifa.start     = 1'b0;
        ifa.abort     = 1'b0;
        ifa.signature = 8'hF9;
        ifb.start     = 1'b0;
        ifb.abort     = 1'b0;
        ifb.signature = 8'hF9;
        tick(3);
        reset = 1'b1;
        tick(2);
        chk_idle_a("rst");
        chk("rst_b_busy", ifb.busy, 0);

        // Basic run with golden signature, then signature changes while in DONE
        pulse_a(k);
        push_a(k, 1);
        chk("a_init_cycle1", ifa.init, 1);
        wait_a(40);
        tick(1);
        ifa.signature = 8'h00;
        tick(3);
        chk("a_pf_hold", ifa.pass_fail, 1);
        chk("a_end_hold", ifa.bist_end, 1);

        // Off-by-one signature fails; new start clears bist_end
        ifa.signature = 8'hF8;
        pulse_a(k);
        push_a(k, 0);
        chk("a_end_cleared", ifa.bist_end, 0);
        chk("a_pidx_cleared", ifa.pattern_idx, 0);
        wait_a(40);
        ifa.signature = 8'hF9;

        // start held high for 40 cycles, then a fresh rising edge at +45
        tick(1);
        k         = cyc;
        ifa.start = 1'b1;
        push_a(k, 1);
        while (cyc < k + 40) tick(1);
        chk("a_first_done", qa.size(), 0);
        chk("a_no_retrigger_busy", ifa.busy, 0);
        chk("a_no_retrigger_end", ifa.bist_end, 1);
        ifa.start = 1'b0;
        while (cyc < k + 45) tick(1);
        ifa.start = 1'b1;
        push_a(k + 45, 1);
        tick(1);
        chk("a_end_falls", ifa.bist_end, 0);
        ifa.start = 1'b0;
        wait_a(40);

        // abort ignored in DONE
        ifa.abort = 1'b1;
        tick(2);
        ifa.abort = 1'b0;
        chk("a_abort_done_end", ifa.bist_end, 1);
        chk("a_abort_done_pf", ifa.pass_fail, 1);

        // abort during SHIFT (cycle 9)
        pulse_a(k);
        while (cyc < k + 9) tick(1);
        chk("a_shift_at9", ifa.scan_en, 1);
        ifa.abort = 1'b1;
        tick(1);
        ifa.abort = 1'b0;
        chk_idle_a("abort");
        tick(4);
        chk("a_abort_stays_idle", ifa.busy, 0);

        // start edge together with abort in IDLE: start wins
        ifa.abort = 1'b1;
        pulse_a(k);
        ifa.abort = 1'b0;
        push_a(k, 1);
        wait_a(40);

        // async reset in CAPTURE, released with start high
        tick(2);
        pulse_a(k);
        n = 0;
        while (!ifa.capture && n < 20) begin
            tick(1);
            n++;
        end
        chk("a_capture_seen", ifa.capture, 1);
        reset = 1'b0;
        #1;
        chk_idle_a("async_rst");
        ifa.start = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(6);
        chk("a_no_run_after_rst", ifa.busy, 0);
        chk("a_no_init_after_rst", ifa.init, 0);
        ifa.start = 1'b0;
        tick(2);
        pulse_a(k);
        push_a(k, 1);
        wait_a(40);

        // Default parameters: 2 + 32*9 + 8 = 298 active cycles, bist_end one cycle later
        tick(2);
        k         = cyc;
        ifb.start = 1'b1;
        tick(1);
        ifb.start = 1'b0;
        eb.end_cyc = k + 299;
        eb.pf      = 1;
        eb.pidx    = 32;
        eb.caps    = 32;
        qb.push_back(eb);
        n = 0;
        while (qb.size() != 0 && n < 400) begin
            tick(1);
            n++;
        end
        if (qb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL b_timeout actual=pending required=bist_end within 400 cycles");
        end
        tick(2);
        chk("b_end_hold", ifb.bist_end, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
